// File: rtl/round_key_inv.sv
// Inverse AES-128 key expansion step: derives round key r-1 from round key r.
// Optional build macro ROUND_KEY_INV_PARALLEL_SBOX_EN. When defined, the design
// uses four S-box lanes and finishes SubWord in one cycle. When undefined, one
// shared S-box processes a single byte per cycle.
//
// state | meaning
// IDLE  | waiting for en; key and round_no are captured on accept
// XOR   | forms p1..p3, RotWord(p3) and the Rcon-seeded p0 accumulator
// SUB   | runs SubWord(RotWord(p3)) into p0; the last substitution completes
`timescale 1ns/1ps
module round_key_inv (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic [3:0]   round_no,
    input  logic [127:0] key,
    output logic [127:0] round_key,
    output logic         en_o,
    output logic         busy
);

    typedef enum logic [1:0] {IDLE, XOR, SUB} state_t;

    localparam logic [2047:0] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Entry 0 sits in the top byte of the table, so entry a starts at bit (255-a)*8.
    function automatic logic [7:0] sbox(input logic [7:0] a);
        return SBOX_TBL[{~a, 3'b000} +: 8];
    endfunction

    // Round numbers outside 1..10 intentionally use a zero Rcon.
    function automatic logic [7:0] rcon(input logic [3:0] r);
        case (r)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    state_t         state, state_nxt;
    logic [127:0]   key_q;
    logic [3:0]     rno_q;
    logic [31:0]    p0, p1, p2, p3, rot;
    logic [31:0]    p0_nxt, xor_p3;
    logic           capture, do_xor, do_sub, done;

    assign xor_p3 = key_q[31:0] ^ key_q[63:32];

`ifdef ROUND_KEY_INV_PARALLEL_SBOX_EN
    // All four bytes of RotWord(p3) are substituted in one cycle.
    always_comb begin
        p0_nxt = p0 ^ {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])};
    end
`else
    logic [1:0] idx;
    logic [7:0] sbox_in, sbox_out;

    // A single S-box is shared; idx picks which byte it processes in this cycle.
    always_comb begin
        sbox_in  = rot[31:24];
        case (idx)
            2'd1:    sbox_in = rot[23:16];
            2'd2:    sbox_in = rot[15:8];
            2'd3:    sbox_in = rot[7:0];
            default: sbox_in = rot[31:24];
        endcase
        sbox_out = sbox(sbox_in);
        p0_nxt   = p0;
        case (idx)
            2'd1:    p0_nxt[23:16] = p0[23:16] ^ sbox_out;
            2'd2:    p0_nxt[15:8]  = p0[15:8]  ^ sbox_out;
            2'd3:    p0_nxt[7:0]   = p0[7:0]   ^ sbox_out;
            default: p0_nxt[31:24] = p0[31:24] ^ sbox_out;
        endcase
    end

    // The byte index advances through SUB and returns to 0 after byte 3.
    always_ff @(posedge clk) begin
        if (reset)       idx <= 2'd0;
        else if (do_xor) idx <= 2'd0;
        else if (do_sub) idx <= idx + 2'd1;
    end
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic and datapath strobes.
    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        do_xor    = 1'b0;
        do_sub    = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (en) begin
                    capture   = 1'b1;
                    state_nxt = XOR;
                end
            end
            XOR: begin
                do_xor    = 1'b1;
                state_nxt = SUB;
            end
            SUB: begin
                do_sub = 1'b1;
`ifdef ROUND_KEY_INV_PARALLEL_SBOX_EN
                done   = 1'b1;
`else
                done   = (idx == 2'd3);
`endif
                if (done) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath registers and outputs. round_key changes only on completion.
    always_ff @(posedge clk) begin
        if (reset) begin
            key_q     <= '0;
            rno_q     <= '0;
            p0        <= '0;
            p1        <= '0;
            p2        <= '0;
            p3        <= '0;
            rot       <= '0;
            round_key <= '0;
            en_o      <= 1'b0;
            busy      <= 1'b0;
        end else begin
            en_o <= done;
            if (capture) begin
                key_q <= key;
                rno_q <= round_no;
                busy  <= 1'b1;
            end
            if (do_xor) begin
                p3  <= xor_p3;
                p2  <= key_q[63:32] ^ key_q[95:64];
                p1  <= key_q[95:64] ^ key_q[127:96];
                rot <= {xor_p3[23:0], xor_p3[31:24]};
                p0  <= key_q[127:96] ^ {rcon(rno_q), 24'h000000};
            end
            if (do_sub) p0 <= p0_nxt;
            if (done) begin
                round_key <= {p0_nxt, p1, p2, p3};
                busy      <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_round_key_inv.sv
// Scoreboard bench for round_key_inv using the AES-128 key schedule vectors.
`timescale 1ns/1ps
module tb_round_key_inv;

    logic         clk = 1'b0;
    logic         reset, en;
    logic [3:0]   round_no;
    logic [127:0] key, round_key;
    logic         en_o, busy;

`ifdef ROUND_KEY_INV_PARALLEL_SBOX_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 5;
`endif

    round_key_inv dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .round_no  (round_no),
        .key       (key),
        .round_key (round_key),
        .en_o      (en_o),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [127:0] rk;
        int           due;
        string        name;
    } exp_t;

    exp_t         q[$];
    int           errors = 0;
    int           checks = 0;
    logic [127:0] rk_tab [0:10];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every en_o cycle must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (en_o === 1'b1) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_en_o: en_o=1 at cycle %0d with nothing outstanding", cyc);
            end else begin
                e = q.pop_front();
                chk({e.name, "_rk"}, round_key, e.rk);
                chk({e.name, "_cycle"}, 128'(cyc), 128'(e.due));
            end
        end
    end

    // Drive one request from just after a rising edge. Returns just after the accept edge.
    task automatic issue(input logic [127:0] k, input logic [3:0] r, input logic [127:0] exp,
                         input string name, input bit push);
        key      = k;
        round_no = r;
        en       = 1'b1;
        if (push) q.push_back('{exp, cyc + 1 + LAT, name});
        @(posedge clk); #1;
        en = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (en_o !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (en_o !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: en_o not seen within 20 cycles", name);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rk_tab[0]  = 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c;
        rk_tab[1]  = 128'ha0fafe17_88542cb1_23a33939_2a6c7605;
        rk_tab[2]  = 128'hf2c295f2_7a96b943_5935807a_7359f67f;
        rk_tab[3]  = 128'h3d80477d_4716fe3e_1e237e44_6d7a883b;
        rk_tab[4]  = 128'hef44a541_a8525b7f_b671253b_db0bad00;
        rk_tab[5]  = 128'hd4d1c6f8_7c839d87_caf2b8bc_11f915bc;
        rk_tab[6]  = 128'h6d88a37a_110b3efd_dbf98641_ca0093fd;
        rk_tab[7]  = 128'h4e54f70e_5f5fc9f3_84a64fb2_4ea6dc4f;
        rk_tab[8]  = 128'head27321_b58dbad2_312bf560_7f8d292f;
        rk_tab[9]  = 128'hac7766f3_19fadc21_28d12941_575c006e;
        rk_tab[10] = 128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6;

        reset = 1'b1; en = 1'b0; key = '0; round_no = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_round_key", round_key, '0);
        chk("reset_en_o", 128'(en_o), 128'(0));
        chk("reset_busy", 128'(busy), 128'(0));

        // Round 1 -> cipher key; request presented at the first edge with reset low.
        reset = 1'b0;
        issue(rk_tab[1], 4'd1, rk_tab[0], "r1", 1'b1);
        chk("r1_busy", 128'(busy), 128'(1));
        chk("r1_hold", round_key, '0);
        wait_done("r1");
        chk("r1_busy_clear", 128'(busy), 128'(0));

        // Round 10 -> round 9; previous result must stay visible until completion.
        @(posedge clk); #1;
        issue(rk_tab[10], 4'd10, rk_tab[9], "r10", 1'b1);
        repeat (LAT - 1) @(posedge clk);
        #1;
        chk("r10_hold", round_key, rk_tab[0]);
        wait_done("r10");

        // A second en while busy must be ignored.
        @(posedge clk); #1;
        issue(rk_tab[2], 4'd2, rk_tab[1], "busy_ign", 1'b1);
        key = rk_tab[5]; round_no = 4'd5; en = 1'b1;
        @(posedge clk); #1;
        en = 1'b0;
        wait_done("busy_ign");
        repeat (8) @(posedge clk);
        #1;

        // Chain 10 -> 1, reissuing in each en_o cycle with round_key fed back.
        issue(rk_tab[10], 4'd10, rk_tab[9], "chain10", 1'b1);
        for (int r = 9; r >= 1; r--) begin
            wait_done($sformatf("chain%0d_wait", r + 1));
            issue(round_key, 4'(r), rk_tab[r - 1], $sformatf("chain%0d", r), 1'b1);
        end
        wait_done("chain1_wait");
        @(posedge clk); #1;
        chk("chain_final", round_key, rk_tab[0]);

        // Reset two cycles after accept, with en also high, aborts the operation.
        issue(rk_tab[1], 4'd1, '0, "rst", 1'b0);
        @(posedge clk); #1;
        reset = 1'b1; en = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0; en = 1'b0;
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_en_o", 128'(en_o), 128'(0));
        chk("rst_round_key", round_key, '0);
        repeat (8) @(posedge clk);
        #1;
        chk("rst_idle_busy", 128'(busy), 128'(0));
        issue(rk_tab[1], 4'd1, rk_tab[0], "post_rst", 1'b1);
        wait_done("post_rst");

        // Round numbers outside 1..10 use Rcon=00: byte 0 becomes 2b^01 = 2a.
        @(posedge clk); #1;
        issue(rk_tab[1], 4'd0, 128'h2a7e1516_28aed2a6_abf71588_09cf4f3c, "rno0", 1'b1);
        wait_done("rno0");
        @(posedge clk); #1;
        issue(rk_tab[1], 4'd11, 128'h2a7e1516_28aed2a6_abf71588_09cf4f3c, "rno11", 1'b1);
        wait_done("rno11");
        @(posedge clk); #1;
        issue(rk_tab[1], 4'd15, 128'h2a7e1516_28aed2a6_abf71588_09cf4f3c, "rno15", 1'b1);
        wait_done("rno15");

        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL outstanding: %0d expected results never appeared", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/round_key_inv.md
ROUND_KEY_INV -- requirements
Module: round_key_inv

Interface
REQ-001 Parameters: none; widths come from aes.vh macros (`KEY_S = 128, `Nb = 4).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 en  input  1  request strobe, sampled on rising edge of clk.
REQ-005 round_no  input  `Nb  index r (1..10) of the round key presented on key.
REQ-006 key  input  `KEY_S  round key r; key[127:96] = word 0, key[127:120] = byte 0.
REQ-007 round_key  output  `KEY_S  registered round key r-1 (same byte order as key).
REQ-008 en_o  output  1  one-cycle done pulse; round_key valid while en_o=1 and held until the next completion or reset.
REQ-009 busy  output  1  high from the request-accept edge until the completion edge.

Function
REQ-010 Inverse key expansion: with k0..k3 the words of key, p3=k3^k2, p2=k2^k1, p1=k1^k0, p0=k0^SubWord(RotWord(p3))^{Rcon[r],00,00,00}; round_key={p0,p1,p2,p3}.
REQ-011 Rcon[1..10] = 01,02,04,08,10,20,40,80,1B,36; round_no 0 or >10 uses Rcon=00 and still completes normally.
REQ-012 FSM states IDLE, XOR, SUB; reset state IDLE.
REQ-013 IDLE: en=1 at edge N -> capture key and round_no, busy=1, go to XOR; en=0 -> stay.
REQ-014 XOR: edge N+1 -> register p1..p3 and RotWord(p3), clear byte index, go to SUB.
REQ-015 SUB (serial): one shared forward S-box; edges N+2..N+5 substitute byte index 0..3, one per edge, into the p0 accumulator.
REQ-016 At edge N+5: write round_key, en_o=1 for exactly one cycle, busy=0, go to IDLE.
REQ-017 en while busy=1 is ignored; captured key/round_no do not change mid-operation.
REQ-018 en=1 in the cycle en_o=1 (state IDLE) is accepted; back-to-back throughput one result per 6 cycles (serial).
REQ-019 Byte index wraps 3 -> done only; no index value above 3 is ever used.
REQ-020 round_key is not modified until the completion edge; the previous result stays visible during processing.

Reset
REQ-021 reset=1 at any edge: state=IDLE, busy=0, en_o=0, round_key=0, byte index=0, internal registers cleared.
REQ-022 reset mid-operation aborts with no en_o pulse; reset dominates en in the same cycle.
REQ-023 First request accepted at the first edge with reset=0 and en=1.

Configuration
REQ-024 Macro ROUND_KEY_INV_PARALLEL_SBOX_EN.
REQ-025 Defined: four S-box lanes; SUB lasts one cycle; completion, en_o pulse and busy drop at edge N+2; throughput one result per 3 cycles.
REQ-026 Undefined: single S-box lane, serial timing of REQ-015/016; identical round_key results in both builds.

Verification
REQ-027 key=a0fafe17_88542cb1_23a33939_2a6c7605, round_no=1 -> round_key=2b7e1516_28aed2a6_abf71588_09cf4f3c, en_o one pulse 5 cycles after accept (2 with macro).
REQ-028 key=d014f9a8_c9ee2589_e13f0cc8_b6630ca6, round_no=10 -> round_key=ac7766f3_19fadc21_28d12941_575c006e.
REQ-029 key=f2c295f2_7a96b943_5935807a_7359f67f, round_no=2, second en pulsed during busy -> single en_o, round_key=a0fafe17_88542cb1_23a33939_2a6c7605.
REQ-030 Chain rounds 10 down to 1, re-issuing en in each en_o cycle with round_key fed back -> final result 2b7e1516_28aed2a6_abf71588_09cf4f3c, each step 6 cycles apart.
REQ-031 reset asserted 2 cycles after accept -> no en_o, round_key=0, busy=0; next request completes correctly.
REQ-032 round_no=0 with any key -> completes with Rcon=00 (p0=k0^SubWord(RotWord(p3))), en_o pulses once.
